dlx_decode_stage: RTL and testbench

//  DLX instruction decode stage between fetch and execute. Takes a 32-bit instruction word and its PC over
//  a valid/ready handshake and classifies it with the DLXOpCodes enums (RType/IType/JType). Extracts register

---
 rtl/dlx_decode_stage_pkg.sv | 56 +++++
 rtl/dlx_decode_stage_skid_buffer.sv | 72 +++++++
 rtl/dlx_decode_stage.sv | 109 ++++++++++
 tb/tb_dlx_decode_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dlx_decode_stage_pkg.sv
// DLX opcode constants, decoded-bundle types and stage widths.
package dlx_decode_stage_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] RTYPE_OP = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_LUI, ALU_PASS
  } alu_op_t;

  typedef enum logic [1:0] {CL_R, CL_I, CL_J, CL_ILL} instr_class_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    instr_class_t      cls;
    alu_op_t           alu_op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jump;
    logic              illegal;
  } dlx_decoded_t;

endpackage

// File: rtl/dlx_decode_stage_skid_buffer.sv
// Two-entry FIFO-ordered valid/ready skid buffer with flush; outputs come straight from flops.
module dlx_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         v0_q, v0_d, v1_q, v1_d;
  logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  // Entry 0 is the head; entry 1 only fills when the head is stalled.
  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    d0_d = d0_q;
    d1_d = d1_q;
    push = in_valid && in_ready_q && !flush;
    pop  = v0_q && out_ready;
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      if (pop) begin
        v0_d = v1_q;
        d0_d = d1_q;
        v1_d = 1'b0;
      end
      if (push) begin
        if (!v0_d) begin
          v0_d = 1'b1;
          d0_d = in_data;
        end else begin
          v1_d = 1'b1;
          d1_d = in_data;
        end
      end
    end
    in_ready_d = !(v0_d && v1_d);
  end

  // Buffer state registers; reset empties both entries and zeroes the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = v0_q;
  assign out_data  = d0_q;

endmodule

// File: rtl/dlx_decode_stage.sv
// DLX decode stage: classifies the fetched word and forwards a registered control bundle.
module dlx_decode_stage
  import dlx_decode_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_instr,
  input  logic [PC_W-1:0]                  in_pc,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$bits(dlx_decoded_t)-1:0]  out_dec
);

  localparam int unsigned DEC_W = $bits(dlx_decoded_t);

  // Pure decode of one instruction word; illegal encodings carry no side effects.
  function automatic dlx_decoded_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    dlx_decoded_t d;
    logic [5:0]   op;
    logic [5:0]   funct;
    logic [15:0]  imm16;
    op    = instr[31:26];
    funct = instr[5:0];
    imm16 = instr[15:0];
    d        = '0;
    d.pc     = pc;
    d.rs1    = instr[25:21];
    d.rs2    = instr[20:16];
    d.rd     = instr[20:16];
    d.cls    = CL_I;
    d.alu_op = ALU_ADD;
    d.imm    = {{16{imm16[15]}}, imm16};
    case (op)
      RTYPE_OP: begin
        d.cls    = CL_R;
        d.rd     = instr[15:11];
        d.imm    = '0;
        d.reg_we = 1'b1;
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_ADDU: d.alu_op = ALU_ADDU;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_SUBU: d.alu_op = ALU_SUBU;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_XOR:  d.alu_op = ALU_XOR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_SLT:  d.alu_op = ALU_SLT;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ADDI: d.reg_we = 1'b1;
      OP_SUBI: begin d.alu_op = ALU_SUB; d.reg_we = 1'b1; end
      OP_SLTI: begin d.alu_op = ALU_SLT; d.reg_we = 1'b1; end
      OP_ANDI: begin d.alu_op = ALU_AND; d.reg_we = 1'b1; d.imm = {16'h0, imm16}; end
      OP_ORI:  begin d.alu_op = ALU_OR;  d.reg_we = 1'b1; d.imm = {16'h0, imm16}; end
      OP_XORI: begin d.alu_op = ALU_XOR; d.reg_we = 1'b1; d.imm = {16'h0, imm16}; end
      OP_LUI:  begin d.alu_op = ALU_LUI; d.reg_we = 1'b1; d.imm = {imm16, 16'h0}; end
      OP_LW:   begin d.mem_rd = 1'b1; d.reg_we = 1'b1; end
      OP_SW:   d.mem_wr = 1'b1;
      OP_BEQZ: begin d.alu_op = ALU_PASS; d.branch = 1'b1; end
      OP_J: begin
        d.cls    = CL_J;
        d.alu_op = ALU_PASS;
        d.rd     = '0;
        d.imm    = {{6{instr[25]}}, instr[25:0]};
        d.jump   = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.cls    = CL_ILL;
      d.alu_op = ALU_PASS;
      d.rd     = '0;
      d.imm    = '0;
      d.reg_we = 1'b0;
      d.mem_rd = 1'b0;
      d.mem_wr = 1'b0;
      d.branch = 1'b0;
      d.jump   = 1'b0;
    end
    // r0 is hard-wired zero: writes to it are dropped, the instruction still flows.
    if (d.rd == '0) d.reg_we = 1'b0;
    return d;
  endfunction

  dlx_decoded_t dec_c;

  // Decode the presented word every cycle; it is captured only on a push.
  always_comb begin
    dec_c = decode(in_instr, in_pc);
  end

  dlx_skid_buffer #(.W(DEC_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (DEC_W'(dec_c)),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_dec)
  );

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Directed, table-driven bench for the DLX decode stage.
module tb_dlx_decode_stage;
  import dlx_decode_stage_pkg::*;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [31:0]  in_pc;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  dlx_decoded_t out_dec;

  int n_tests = 0;
  int n_fail  = 0;

  dlx_decode_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  instr;
    logic [31:0]  pc;
    dlx_decoded_t exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flags = {reg_we, mem_rd, mem_wr, branch, jump, illegal}
  function automatic dlx_decoded_t mk(input logic [31:0] pc, input instr_class_t cls, input alu_op_t alu,
                                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                      input logic [31:0] imm, input logic [5:0] flags);
    dlx_decoded_t d;
    d.pc = pc; d.cls = cls; d.alu_op = alu; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.imm = imm;
    {d.reg_we, d.mem_rd, d.mem_wr, d.branch, d.jump, d.illegal} = flags;
    return d;
  endfunction

  vec_t        vecs[14];
  logic [31:0] st_instr[4];
  logic [31:0] st_pc[4];
  logic [31:0] got_pc[4];
  int          idx;
  int          got;

  initial begin
    vecs[0]  = '{32'h00221820, 32'h100, mk(32'h100, CL_R, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 6'b100000)};
    vecs[1]  = '{{6'h0D, 5'd0, 5'd4, 16'h8001}, 32'h104, mk(32'h104, CL_I, ALU_OR, 5'd0, 5'd4, 5'd4, 32'h00008001, 6'b100000)};
    vecs[2]  = '{{6'h08, 5'd0, 5'd4, 16'h8001}, 32'h108, mk(32'h108, CL_I, ALU_ADD, 5'd0, 5'd4, 5'd4, 32'hFFFF8001, 6'b100000)};
    vecs[3]  = '{{6'h0F, 5'd0, 5'd5, 16'h1234}, 32'h10C, mk(32'h10C, CL_I, ALU_LUI, 5'd0, 5'd5, 5'd5, 32'h12340000, 6'b100000)};
    vecs[4]  = '{{6'h2B, 5'd2, 5'd7, 16'h0008}, 32'h110, mk(32'h110, CL_I, ALU_ADD, 5'd2, 5'd7, 5'd7, 32'h00000008, 6'b001000)};
    vecs[5]  = '{{6'h04, 5'd3, 5'd0, 16'hFFFC}, 32'h114, mk(32'h114, CL_I, ALU_PASS, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFC, 6'b000100)};
    vecs[6]  = '{{6'h02, 26'h3FFFFFC}, 32'h118, mk(32'h118, CL_J, ALU_PASS, 5'd31, 5'd31, 5'd0, 32'hFFFFFFFC, 6'b000010)};
    vecs[7]  = '{32'h00220020, 32'h11C, mk(32'h11C, CL_R, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'h0, 6'b000000)};
    vecs[8]  = '{{6'h23, 5'd1, 5'd6, 16'hFFF0}, 32'h120, mk(32'h120, CL_I, ALU_ADD, 5'd1, 5'd6, 5'd6, 32'hFFFFFFF0, 6'b110000)};
    vecs[9]  = '{{6'h3F, 5'd1, 5'd2, 16'h1234}, 32'h124, mk(32'h124, CL_ILL, ALU_PASS, 5'd1, 5'd2, 5'd0, 32'h0, 6'b000001)};
    vecs[10] = '{{6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h128, mk(32'h128, CL_ILL, ALU_PASS, 5'd1, 5'd2, 5'd0, 32'h0, 6'b000001)};
    vecs[11] = '{{6'h0A, 5'd8, 5'd9, 16'h0005}, 32'h12C, mk(32'h12C, CL_I, ALU_SUB, 5'd8, 5'd9, 5'd9, 32'h00000005, 6'b100000)};
    vecs[12] = '{{6'h0E, 5'd1, 5'd10, 16'hFFFF}, 32'h130, mk(32'h130, CL_I, ALU_XOR, 5'd1, 5'd10, 5'd10, 32'h0000FFFF, 6'b100000)};
    vecs[13] = '{{6'h00, 5'd2, 5'd3, 5'd11, 5'd0, 6'h2A}, 32'h134, mk(32'h134, CL_R, ALU_SLT, 5'd2, 5'd3, 5'd11, 32'h0, 6'b100000)};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_dec", 128'(out_dec), 128'(0));
    reset = 1'b0;

    // Back-to-back decode, one instruction per cycle, 1-cycle latency
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("vec%0d_dec", i), 128'(out_dec), 128'(vecs[i].exp));
    end
    repeat (2) @(negedge clk);
    chk("drained_valid", 128'(out_valid), 128'(0));

    // Stall: 4 offered, 2 accepted, then drain and resume in order
    for (int k = 0; k < 4; k++) begin
      st_instr[k] = {6'h00, 5'd1, 5'd2, 5'(k + 12), 5'd0, 6'h20};
      st_pc[k]    = 32'h200 + 32'(k * 4);
      got_pc[k]   = '0;
    end
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      if (cyc >= 2 && cyc <= 5) chk($sformatf("stall_hold_pc_c%0d", cyc), 128'(out_dec.pc), 128'(st_pc[0]));
      if (cyc == 5) begin
        chk("stall_in_ready", 128'(in_ready), 128'(0));
        chk("stall_accepted", 128'(idx), 128'(2));
        chk("stall_out_valid", 128'(out_valid), 128'(1));
      end
      in_valid = (idx < 4);
      if (idx < 4) begin in_instr = st_instr[idx]; in_pc = st_pc[idx]; end
      if (out_valid && out_ready) begin got_pc[got] = out_dec.pc; got++; end
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_delivered", 128'(got), 128'(4));
    for (int k = 0; k < 4; k++) chk($sformatf("stall_order%0d", k), 128'(got_pc[k]), 128'(st_pc[k]));
    @(negedge clk);
    chk("stall_empty", 128'(out_valid), 128'(0));

    // Flush with both entries full and a beat offered
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h300;
    @(negedge clk); in_pc = 32'h304;
    @(negedge clk); in_pc = 32'h308;
    chk("flush_full_in_ready", 128'(in_ready), 128'(0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_out_valid", 128'(out_valid), 128'(0));
    chk("flush_full_in_ready_after", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush_full_quiet%0d", k), 128'(out_valid), 128'(0));
    end

    // Flush with one entry held and an acceptable beat offered
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_pc = 32'h400;
    @(negedge clk); in_pc = 32'h404; flush = 1'b1;
    chk("flush_one_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_one_out_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush_one_quiet%0d", k), 128'(out_valid), 128'(0));
    end

    // Reset pulsed in the middle of a stall
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = vecs[3].instr; in_pc = 32'h500;
    @(negedge clk); in_pc = 32'h504;
    @(negedge clk); in_valid = 1'b0;
    chk("pre_reset_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    chk("midreset_in_ready", 128'(in_ready), 128'(1));
    chk("midreset_out_dec", 128'(out_dec), 128'(0));
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
